// File: rtl/data_mem_resp_if.sv
// EX/MEM request bundle and registered write-back bundle of the data memory responder.
interface data_mem_resp_if;
  logic        ram_r_ena_i;
  logic [31:0] ram_r_addr_i;
  logic        ram_w_ena_i;
  logic [31:0] ram_w_addr_i;
  logic [31:0] ram_w_data_i;
  logic [2:0]  funct3_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        hold_req_o;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  modport master (
    output ram_r_ena_i, ram_r_addr_i, ram_w_ena_i, ram_w_addr_i, ram_w_data_i,
           funct3_i, reg_w_ena_i, reg_w_addr_i, reg_w_data_i,
    input  hold_req_o, reg_w_ena_o, reg_w_addr_o, reg_w_data_o,
           misalign_o, misalign_addr_o
  );

  modport slave (
    input  ram_r_ena_i, ram_r_addr_i, ram_w_ena_i, ram_w_addr_i, ram_w_data_i,
           funct3_i, reg_w_ena_i, reg_w_addr_i, reg_w_data_i,
    output hold_req_o, reg_w_ena_o, reg_w_addr_o, reg_w_data_o,
           misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/data_mem_resp.sv
// MEM-stage responder: byte-lane data RAM with RV32I load/store formatting,
// one stall cycle per load and a registered write-back bundle for WB.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic           clk_100M,
  input  logic           arst_n,
  input  logic           clear,
  data_mem_resp_if.slave bus
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] r_idx, w_idx;
  logic          ld_f3_ok, st_f3_ok;
  logic          fault, ld_go, st_go;
  logic [31:0]   fault_addr;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  logic [31:0]   rd_word_p1;
  logic [1:0]    ld_off_p1;
  logic [2:0]    ld_f3_p1;
  logic          ld_rwe_p1;
  logic [4:0]    ld_rd_p1;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{bus.ram_r_addr_i[31:AW+2], bus.ram_w_addr_i[31:AW+2]};

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_fmt = 32'(b);
      3'b100:  load_fmt = {24'h0, b};
      3'b001:  load_fmt = 32'(h);
      3'b101:  load_fmt = {16'h0, h};
      default: load_fmt = w;
    endcase
  endfunction

  assign r_idx    = bus.ram_r_addr_i[AW+1:2];
  assign w_idx    = bus.ram_w_addr_i[AW+1:2];
  assign ld_f3_ok = bus.funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_f3_ok = bus.funct3_i inside {3'b000, 3'b001, 3'b010};

  // Request decode; only meaningful in IDLE, requests are ignored in LOAD_WAIT
  always_comb begin
    fault      = 1'b0;
    fault_addr = bus.ram_r_ena_i ? bus.ram_r_addr_i : bus.ram_w_addr_i;
    if (state == IDLE) begin
      if (bus.ram_r_ena_i && bus.ram_w_ena_i)
        fault = 1'b1;
      else if (bus.ram_r_ena_i)
        fault = !ld_f3_ok || misaligned(bus.funct3_i, bus.ram_r_addr_i[1:0]);
      else if (bus.ram_w_ena_i)
        fault = !st_f3_ok || misaligned(bus.funct3_i, bus.ram_w_addr_i[1:0]);
    end
  end

  assign ld_go = (state == IDLE) && bus.ram_r_ena_i && !fault;
  assign st_go = (state == IDLE) && bus.ram_w_ena_i && !fault && !clear;

  always_comb begin
    st_be   = 4'b0000;
    st_data = bus.ram_w_data_i;
    case (bus.funct3_i)
      3'b000: begin
        st_be   = 4'b0001 << bus.ram_w_addr_i[1:0];
        st_data = {4{bus.ram_w_data_i[7:0]}};
      end
      3'b001: begin
        st_be   = bus.ram_w_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.ram_w_data_i[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_100M or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.hold_req_o = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ld_go) begin
          state_nxt      = LOAD_WAIT;
          bus.hold_req_o = arst_n;
        end
        LOAD_WAIT: state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100M) begin
    if (st_go) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i]) mem[w_idx][i*8 +: 8] <= st_data[i*8 +: 8];
    end
  end

  // p0 -> p1: RAM read and load context capture on the request edge
  always_ff @(posedge clk_100M) begin
    if (ld_go) begin
      rd_word_p1 <= mem[r_idx];
      ld_off_p1  <= bus.ram_r_addr_i[1:0];
      ld_f3_p1   <= bus.funct3_i;
      ld_rwe_p1  <= bus.reg_w_ena_i;
      ld_rd_p1   <= bus.reg_w_addr_i;
    end
  end

  // p1 -> WB: formatted load data, pass-through fields or fault pulse
  always_ff @(posedge clk_100M or negedge arst_n) begin
    if (!arst_n) begin
      bus.reg_w_ena_o     <= 1'b0;
      bus.reg_w_addr_o    <= 5'd0;
      bus.reg_w_data_o    <= 32'h0;
      bus.misalign_o      <= 1'b0;
      bus.misalign_addr_o <= 32'h0;
    end else if (clear) begin
      bus.reg_w_ena_o  <= 1'b0;
      bus.reg_w_addr_o <= 5'd0;
      bus.reg_w_data_o <= 32'h0;
      bus.misalign_o   <= 1'b0;
    end else if (state == LOAD_WAIT) begin
      bus.reg_w_ena_o  <= ld_rwe_p1;
      bus.reg_w_addr_o <= ld_rd_p1;
      bus.reg_w_data_o <= load_fmt(rd_word_p1, ld_off_p1, ld_f3_p1);
      bus.misalign_o   <= 1'b0;
    end else if (fault) begin
      bus.reg_w_ena_o     <= 1'b0;
      bus.misalign_o      <= 1'b1;
      bus.misalign_addr_o <= fault_addr;
    end else if (ld_go) begin
      bus.reg_w_ena_o <= 1'b0;
      bus.misalign_o  <= 1'b0;
    end else begin
      bus.reg_w_ena_o  <= bus.reg_w_ena_i;
      bus.reg_w_addr_o <= bus.reg_w_addr_i;
      bus.reg_w_data_o <= bus.reg_w_data_i;
      bus.misalign_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: vector table of loads/stores plus hand sequences
// for RAW, back-to-back loads, clear and asynchronous reset; write-backs scored from a queue.
module tb_data_mem_resp;

  logic clk_100M = 1'b0;
  logic arst_n   = 1'b0;
  logic clear    = 1'b0;

  data_mem_resp_if bus();

  data_mem_resp #(.DEPTH_WORDS(4096), .AW(12)) dut (
    .clk_100M (clk_100M),
    .arst_n   (arst_n),
    .clear    (clear),
    .bus      (bus)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct {
    logic        fault;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        fault;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every write-back or fault pulse must match the oldest expected record
  always @(negedge clk_100M) begin
    if (mon_en && arst_n && (bus.reg_w_ena_o || bus.misalign_o)) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: ena=%b addr=%0d data=%h misalign=%b, nothing expected",
                 bus.reg_w_ena_o, bus.reg_w_addr_o, bus.reg_w_data_o, bus.misalign_o);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.fault) begin
          chk("fault_pulse", 32'(bus.misalign_o), 32'd1);
          chk("fault_addr", bus.misalign_addr_o, mon_e.val);
          chk("fault_wb_ena", 32'(bus.reg_w_ena_o), 32'd0);
        end else begin
          chk("wb_addr", 32'(bus.reg_w_addr_o), 32'(mon_e.rd));
          chk("wb_data", bus.reg_w_data_o, mon_e.val);
          chk("wb_no_fault", 32'(bus.misalign_o), 32'd0);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [2:0] f3, input logic rwe,
                       input logic [4:0] rwa, input logic [31:0] rwd);
    bus.ram_r_ena_i  = r;
    bus.ram_w_ena_i  = w;
    bus.ram_r_addr_i = ra;
    bus.ram_w_addr_i = wa;
    bus.ram_w_data_i = wd;
    bus.funct3_i     = f3;
    bus.reg_w_ena_i  = rwe;
    bus.reg_w_addr_i = rwa;
    bus.reg_w_data_i = rwd;
  endtask

  task automatic step(input logic exp_hold, input string nm);
    #2;
    chk(nm, 32'(bus.hold_req_o), 32'(exp_hold));
    @(posedge clk_100M);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3'd0, 0, 5'd0, 0);
    step(1'b0, "hold_idle");
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] exp);
    drive(1, 0, a, 0, 0, f3, 1, rd, 32'h0);
    sbq.push_back('{fault: 1'b0, rd: rd, val: exp});
    step(1'b1, "hold_load");
    step(1'b0, "hold_load_wait");
  endtask

  function automatic vec_t v(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] exp,
                             input logic fault);
    v = '{ld: ld, addr: addr, wd: wd, f3: f3, rd: rd, exp: exp, fault: fault};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    //            ld  addr        wdata        f3    rd     expected     fault
    tbl.push_back(v(0, 32'h100,  32'hDEADBEEF, 3'd2, 5'd0,  32'h0,        0));
    tbl.push_back(v(1, 32'h100,  32'h0,        3'd2, 5'd5,  32'hDEADBEEF, 0));
    tbl.push_back(v(0, 32'h200,  32'h11223344, 3'd2, 5'd0,  32'h0,        0));
    tbl.push_back(v(0, 32'h203,  32'hABCDEF80, 3'd0, 5'd0,  32'h0,        0));
    tbl.push_back(v(1, 32'h203,  32'h0,        3'd0, 5'd1,  32'hFFFFFF80, 0));
    tbl.push_back(v(1, 32'h203,  32'h0,        3'd4, 5'd2,  32'h00000080, 0));
    tbl.push_back(v(1, 32'h200,  32'h0,        3'd2, 5'd3,  32'h80223344, 0));
    tbl.push_back(v(0, 32'h202,  32'h12348001, 3'd1, 5'd0,  32'h0,        0));
    tbl.push_back(v(1, 32'h202,  32'h0,        3'd1, 5'd4,  32'hFFFF8001, 0));
    tbl.push_back(v(1, 32'h202,  32'h0,        3'd5, 5'd6,  32'h00008001, 0));
    tbl.push_back(v(1, 32'h200,  32'h0,        3'd1, 5'd8,  32'h00003344, 0));
    tbl.push_back(v(1, 32'h201,  32'h0,        3'd0, 5'd9,  32'h00000033, 0));
    tbl.push_back(v(1, 32'h200,  32'h0,        3'd4, 5'd10, 32'h00000044, 0));
    tbl.push_back(v(1, 32'h200,  32'h0,        3'd2, 5'd11, 32'h80013344, 0));
    tbl.push_back(v(1, 32'h102,  32'h0,        3'd2, 5'd0,  32'h102,      1));
    tbl.push_back(v(0, 32'h101,  32'h0000FFFF, 3'd1, 5'd0,  32'h101,      1));
    tbl.push_back(v(1, 32'h100,  32'h0,        3'd2, 5'd12, 32'hDEADBEEF, 0));
    tbl.push_back(v(1, 32'h103,  32'h0,        3'd1, 5'd0,  32'h103,      1));
    tbl.push_back(v(0, 32'h4000, 32'hCAFEF00D, 3'd2, 5'd0,  32'h0,        0));
    tbl.push_back(v(1, 32'h0,    32'h0,        3'd2, 5'd13, 32'hCAFEF00D, 0));
    tbl.push_back(v(1, 32'h0,    32'h0,        3'd3, 5'd0,  32'h0,        1));
    tbl.push_back(v(1, 32'h4,    32'h0,        3'd6, 5'd0,  32'h4,        1));
    tbl.push_back(v(0, 32'h100,  32'h01010101, 3'd3, 5'd0,  32'h100,      1));
    tbl.push_back(v(0, 32'h100,  32'h02020202, 3'd4, 5'd0,  32'h100,      1));
    tbl.push_back(v(1, 32'h100,  32'h0,        3'd2, 5'd14, 32'hDEADBEEF, 0));
    tbl.push_back(v(0, 32'h101,  32'h777777AA, 3'd0, 5'd0,  32'h0,        0));
    tbl.push_back(v(0, 32'h100,  32'h99995555, 3'd1, 5'd0,  32'h0,        0));
    tbl.push_back(v(1, 32'h100,  32'h0,        3'd2, 5'd15, 32'hDEAD5555, 0));
    tbl.push_back(v(1, 32'h102,  32'h0,        3'd5, 5'd16, 32'h0000DEAD, 0));
    tbl.push_back(v(1, 32'h100,  32'h0,        3'd1, 5'd17, 32'h00005555, 0));

    drive(0, 0, 0, 0, 0, 3'd0, 0, 5'd0, 0);
    #3;
    chk("rst_wb_ena", 32'(bus.reg_w_ena_o), 32'd0);
    chk("rst_wb_addr", 32'(bus.reg_w_addr_o), 32'd0);
    chk("rst_wb_data", bus.reg_w_data_o, 32'h0);
    chk("rst_misalign", 32'(bus.misalign_o), 32'd0);
    chk("rst_misalign_addr", bus.misalign_addr_o, 32'h0);
    chk("rst_hold", 32'(bus.hold_req_o), 32'd0);
    @(posedge clk_100M);
    @(posedge clk_100M);
    #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    idle();

    foreach (tbl[i]) begin
      if (tbl[i].ld) begin
        if (tbl[i].fault) begin
          drive(1, 0, tbl[i].addr, 0, 0, tbl[i].f3, 1, tbl[i].rd, 32'h0);
          sbq.push_back('{fault: 1'b1, rd: 5'd0, val: tbl[i].exp});
          step(1'b0, "hold_fault_load");
        end else begin
          load(tbl[i].addr, tbl[i].f3, tbl[i].rd, tbl[i].exp);
        end
      end else begin
        drive(0, 1, 0, tbl[i].addr, tbl[i].wd, tbl[i].f3, 0, 5'd0, 32'h0);
        if (tbl[i].fault) sbq.push_back('{fault: 1'b1, rd: 5'd0, val: tbl[i].exp});
        step(1'b0, "hold_store");
      end
      idle();
    end

    // ALU result pass-through, one cycle latency
    drive(0, 0, 0, 0, 0, 3'd0, 1, 5'd7, 32'h1234);
    sbq.push_back('{fault: 1'b0, rd: 5'd7, val: 32'h1234});
    step(1'b0, "hold_passthru");
    chk("passthru_data", bus.reg_w_data_o, 32'h1234);
    idle();

    // Simultaneous read and write requests fault on the read address
    drive(1, 1, 32'h500, 32'h100, 32'h0, 3'd2, 1, 5'd3, 32'h0);
    sbq.push_back('{fault: 1'b1, rd: 5'd0, val: 32'h500});
    step(1'b0, "hold_both_req");
    idle();
    chk("misalign_addr_holds", bus.misalign_addr_o, 32'h500);
    load(32'h100, 3'd2, 5'd18, 32'hDEAD5555);
    idle();

    // Store immediately followed by load of the same word
    drive(0, 1, 0, 32'h208, 32'h0BADF00D, 3'd2, 0, 5'd0, 32'h0);
    step(1'b0, "hold_raw_store");
    load(32'h208, 3'd2, 5'd19, 32'h0BADF00D);
    // Back-to-back loads
    load(32'h0, 3'd2, 5'd20, 32'hCAFEF00D);
    load(32'h203, 3'd4, 5'd21, 32'h00000080);
    idle();

    // Store suppressed by clear
    clear = 1'b1;
    drive(0, 1, 0, 32'h100, 32'h99999999, 3'd2, 0, 5'd0, 32'h0);
    step(1'b0, "hold_clear_store");
    clear = 1'b0;
    idle();
    load(32'h100, 3'd2, 5'd22, 32'hDEAD5555);
    idle();

    // Clear during LOAD_WAIT drops the load
    drive(1, 0, 32'h0, 0, 0, 3'd2, 1, 5'd23, 32'h0);
    step(1'b1, "hold_clear_load");
    clear = 1'b1;
    step(1'b0, "hold_clear_wait");
    clear = 1'b0;
    chk("clear_wb_ena", 32'(bus.reg_w_ena_o), 32'd0);
    chk("clear_misalign", 32'(bus.misalign_o), 32'd0);
    idle();
    load(32'h0, 3'd2, 5'd24, 32'hCAFEF00D);
    idle();

    // Asynchronous reset during LOAD_WAIT
    drive(1, 0, 32'h0, 0, 0, 3'd2, 1, 5'd25, 32'h0);
    step(1'b1, "hold_arst_load");
    #1;
    arst_n = 1'b0;
    #1;
    chk("arst_wb_ena", 32'(bus.reg_w_ena_o), 32'd0);
    chk("arst_wb_addr", 32'(bus.reg_w_addr_o), 32'd0);
    chk("arst_wb_data", bus.reg_w_data_o, 32'h0);
    chk("arst_misalign", 32'(bus.misalign_o), 32'd0);
    chk("arst_misalign_addr", bus.misalign_addr_o, 32'h0);
    chk("arst_hold", 32'(bus.hold_req_o), 32'd0);
    drive(0, 0, 0, 0, 0, 3'd0, 0, 5'd0, 0);
    @(posedge clk_100M);
    #1;
    arst_n = 1'b1;
    idle();
    load(32'h0, 3'd2, 5'd26, 32'hCAFEF00D);
    idle();
    idle();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Responder side of the EX/MEM memory interface: accepts the registered read/write requests and write-back fields from the EX/MEM pipeline register and services them against an internal synchronous word-organised data RAM. Handles RV32I byte, half and word loads and stores, and asserts a one-cycle stall request per load. Produces the registered write-back bundle for the WB stage. Flags misaligned and illegal accesses.

## Interface
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; power of two.
- AW, 12: word index width, log2(DEPTH_WORDS).

- clk_100M  in  1  clock, 100 MHz
- arst_n  in  1  asynchronous reset, active-low
- clear  in  1  synchronous flush; aborts any in-flight load
- ram_r_ena_i  in  1  load request
- ram_r_addr_i  in  32  load byte address
- ram_w_ena_i  in  1  store request
- ram_w_addr_i  in  32  store byte address
- ram_w_data_i  in  32  store data; bytes taken from the LSBs
- funct3_i  in  3  inst[14:12]; selects access size and sign
- reg_w_ena_i / reg_w_addr_i / reg_w_data_i  in  1/5/32  non-load write-back fields
- hold_req_o  out  1  combinational stall request to ctrl
- reg_w_ena_o / reg_w_addr_o / reg_w_data_o  out  1/5/32  registered write-back to WB
- misalign_o  out  1  registered one-cycle pulse on misaligned or illegal access
- misalign_addr_o  out  32  byte address of the last faulting access; holds its value otherwise

## Operation
- The RAM array is DEPTH_WORDS x 32 with four byte-write lanes. The word index is addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo the RAM size. RAM contents are not reset.
- The FSM has two states: IDLE and LOAD_WAIT.
- **IDLE with an aligned, legal load:**
  - Latch the word index, addr[1:0], funct3 and reg_w_addr_i.
  - hold_req_o=1.
  - Next state is LOAD_WAIT.
- **LOAD_WAIT:**
  - Format the RAM read word and register it onto reg_w_data_o, with reg_w_ena_o equal to the captured reg_w_ena_i.
  - hold_req_o=0. EX/MEM advances at the end of this cycle.
  - Request inputs are ignored in this state.
  - Next state is IDLE.
- **Load formatting** by funct3:
  - 000 LB: byte addr[1:0], sign-extended.
  - 100 LBU: byte addr[1:0], zero-extended.
  - 001 LH: half at addr[1], sign-extended.
  - 101 LHU: half at addr[1], zero-extended.
  - 010 LW: full word.
- **Stores (IDLE only)**, written at the clock edge ending the request cycle:
  - 000 SB: lane addr[1:0] receives data[7:0].
  - 001 SH: lanes {addr[1],0} and {addr[1],1} receive data[15:0].
  - 010 SW: all four lanes.
  - A store is never stalled: hold_req_o=0.
- **Misalignment:**
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - On a misaligned access: no RAM access, no stall, misalign_o=1 for the next cycle, misalign_addr_o captures the address, reg_w_ena_o=0.
- **Illegal accesses**, handled exactly like misalignment (misalign_addr_o takes ram_r_addr_i):
  - ram_r_ena_i and ram_w_ena_i both high.
  - Unlisted funct3: load 011/110/111; store ≥011.
- **No memory request:** reg_w_*_o register reg_w_*_i with 1-cycle latency.
- **clear (priority below arst_n, above everything else):**
  - Next state IDLE.
  - reg_w_*_o and misalign_o go to 0.
  - A store presented in the same cycle is suppressed.
  - An in-flight load is dropped.
  - hold_req_o=0 while clear=1.

## Timing
- **Reset values** (arst_n low): state IDLE, reg_w_ena_o=0, reg_w_addr_o=0, reg_w_data_o=0, misalign_o=0, misalign_addr_o=0, hold_req_o=0.
- **Load:**
  - Request in cycle N: hold_req_o=1 in N, RAM read at edge N.
  - Data valid on reg_w_data_o after edge N+1.
  - Total of one stall cycle per load.
- **Non-load write-back:** request in N, reg_w_*_o valid after edge N.
- **Read-after-write:** a store at edge N followed by a load whose RAM read occurs at edge N+1 returns the new data. No bypass is required.
- **Back-to-back loads:** the second load enters IDLE processing in the cycle after LOAD_WAIT, giving a sustained rate of one load per 2 cycles.
- **Fault pulse:** misalign_o is high exactly one cycle, following the faulting request cycle.

## Test plan
- **Store/load word:** SW 0xDEADBEEF to 0x100, then LW 0x100 to x5 -> hold_req_o high 1 cycle; reg_w_data_o=0xDEADBEEF, reg_w_addr_o=5, reg_w_ena_o=1.
- **Byte/half sign handling:**
  - SB 0x80 to 0x203, then LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080.
  - SH 0x8001 to 0x202, then LH -> 0xFFFF8001; LHU -> 0x00008001.
  - Other bytes of word 0x200 are unchanged.
- **Misaligned:** LW 0x102 -> no stall, misalign_o one-cycle pulse, misalign_addr_o=0x102, reg_w_ena_o=0, memory unchanged. Repeat with SH 0x101.
- **Pass-through and wrap:**
  - ALU result 0x1234 to x7 with no request -> reg_w_data_o=0x1234 one cycle later.
  - With DEPTH_WORDS=4096, SW to 0x4000 then LW from 0x0 -> same data.
- **Clear mid-load:** LW issued, clear asserted in the LOAD_WAIT cycle -> reg_w_ena_o stays 0, state IDLE, hold_req_o=0.
- **Async reset mid-load:** arst_n low during LOAD_WAIT -> all outputs 0 and state IDLE.
